// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   RS232-style serial receiver for 8N1 / 8E1 / 8O1 frames, LSB first.
//   Each received word is presented with a level valid/ack handshake and a
//   per-word error flag (framing or parity). The block feeds the mirror/bridge
//   stage (valid->rxValid, ack<-rxAck, data->rxData, err->rxErr).
//
// Parameters
//   C_CLK_FRQ          master clock frequency [Hz]
//   C_UART_RATE        baud rate [bit/s]; bit period N = C_CLK_FRQ/C_UART_RATE, N >= 4
//   C_UART_DATA_WIDTH  data bits per frame
//   C_UART_PARITY      0 = none, 1 = odd, 2 = even
//
// Ports
//   clk    in   master clock
//   rst    in   synchronous reset, active high
//   rx     in   asynchronous serial line, idle high
//   ack    in   word consumed / error acknowledged
//   valid  out  data/err hold a received word, held until ack
//   data   out  received word, bit 0 = first bit on the line
//   err    out  framing or parity error on the current word (qualified by valid)
//   busy   out  high from start-bit detection until valid rises
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int C_CLK_FRQ         = 100_000_000,
  parameter int C_UART_RATE       = 115_200,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_UART_PARITY     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  input  logic                         ack,
  output logic                         valid,
  output logic [C_UART_DATA_WIDTH-1:0] data,
  output logic                         err,
  output logic                         busy
);

  localparam int N  = C_CLK_FRQ / C_UART_RATE;
  localparam int TW = $clog2(N);
  localparam int CW = $clog2(C_UART_DATA_WIDTH + 1);

  localparam logic [TW-1:0] HALF_TICK = TW'(N / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(N - 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(C_UART_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    sIDLE, sSTART, sDATA, sPARITY, sSTOP, sWAIT, sARM
  } stateT;

  stateT                        state, stateNext;
  logic                         rxMeta, rxS, rxSPrev;
  logic [TW-1:0]                timer;
  logic [CW-1:0]                bitCnt;
  logic [C_UART_DATA_WIDTH-1:0] shiftReg;
  logic                         parBad;

  logic midTick, bitTick, parSum;
  logic timerRestart, shiftEn, parEn, loadOut, clrOut;

  assign midTick = (timer == HALF_TICK);
  assign bitTick = (timer == LAST_TICK);
  assign parSum  = ^shiftReg ^ rxS;
  assign busy    = (state == sSTART) || (state == sDATA) ||
                   (state == sPARITY) || (state == sSTOP);

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All three reset to the idle line level so reset never looks like a start.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxMeta  <= 1'b1;
      rxS     <= 1'b1;
      rxSPrev <= 1'b1;
    end else begin
      rxMeta  <= rx;
      rxS     <= rxMeta;
      rxSPrev <= rxS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= sIDLE;
    else     state <= stateNext;
  end

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    stateNext    = state;
    timerRestart = 1'b0;
    shiftEn      = 1'b0;
    parEn        = 1'b0;
    loadOut      = 1'b0;
    clrOut       = 1'b0;
    case (state)
      sIDLE: begin
        if (rxSPrev && !rxS) begin
          stateNext    = sSTART;
          timerRestart = 1'b1;
        end
      end
      sSTART: begin
        // Start bit must still be low at its centre, otherwise it was a glitch.
        if (midTick) begin
          timerRestart = 1'b1;
          stateNext    = rxS ? sIDLE : sDATA;
        end
      end
      sDATA: begin
        // Timer was restarted at the start-bit centre, so each full period
        // lands on the centre of the next bit.
        if (bitTick) begin
          shiftEn = 1'b1;
          if (bitCnt == LAST_BIT)
            stateNext = (C_UART_PARITY != 0) ? sPARITY : sSTOP;
        end
      end
      sPARITY: begin
        if (bitTick) begin
          parEn     = 1'b1;
          stateNext = sSTOP;
        end
      end
      sSTOP: begin
        if (bitTick) begin
          loadOut   = 1'b1;
          stateNext = sWAIT;
        end
      end
      sWAIT: begin
        // Line is ignored here: frames arriving before ack are dropped.
        if (ack) begin
          clrOut    = 1'b1;
          stateNext = sARM;
        end
      end
      sARM: begin
        // Wait for an idle line so we never lock onto the middle of a frame
        // (or onto a break that is still being held).
        if (rxS) stateNext = sIDLE;
      end
      default: stateNext = sIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      bitCnt   <= '0;
      shiftReg <= '0;
      parBad   <= 1'b0;
      valid    <= 1'b0;
      data     <= '0;
      err      <= 1'b0;
    end else begin
      if (timerRestart || bitTick) timer <= '0;
      else                         timer <= timer + TW'(1);

      if (timerRestart) begin
        bitCnt <= '0;
        parBad <= 1'b0;
      end else if (shiftEn) begin
        bitCnt <= bitCnt + CW'(1);
      end

      if (shiftEn)
        shiftReg <= {rxS, shiftReg[C_UART_DATA_WIDTH-1:1]};

      // Odd parity wants an odd total of ones, even parity an even total.
      if (parEn)
        parBad <= (C_UART_PARITY == 1) ? !parSum : parSum;

      // Data is registered even when the frame is flagged as bad.
      if (loadOut) begin
        valid <= 1'b1;
        data  <= shiftReg;
        err   <= parBad || !rxS;
      end else if (clrOut) begin
        valid <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Three receivers (no parity, odd parity, even parity) with N = 16 clk/bit.
//   Frames are built bit by bit on each receiver's own rx line; the expected
//   word is computed from the frame contents and queued, and a monitor pops
//   and compares whenever a receiver raises valid.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int N = 16;

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic       e;
  } expT;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rxV, ackV, validV, errV, busyV;
  logic [7:0] dataV [3];

  expT  expQ[$];
  expT  curExp [3];
  bit   pending [3];
  bit   latArm [3];
  int   startCycle [3];
  int   cycle = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic [2:0] validPrev = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Instance g uses C_UART_PARITY = g: 0 none, 1 odd, 2 even.
  for (genvar g = 0; g < 3; g++) begin : gDut
    uart_rx_core #(
      .C_CLK_FRQ        (1_600_000),
      .C_UART_RATE      (100_000),
      .C_UART_DATA_WIDTH(8),
      .C_UART_PARITY    (g)
    ) u (
      .clk  (clk),
      .rst  (rst),
      .rx   (rxV[g]),
      .ack  (ackV[g]),
      .valid(validV[g]),
      .data (dataV[g]),
      .err  (errV[g]),
      .busy (busyV[g])
    );
  end

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    compared++;
    if (act < lo || act > hi) begin
      mismatched++;
      if (lo == hi) $display("FAIL %s: got %0d, expected %0d", name, act, lo);
      else          $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checkRange(name, act, exp, exp);
  endtask

  // Monitor: compares on every rising valid, and checks the word stays put.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (validV[i] && !validPrev[i]) begin
        if (latArm[i]) begin
          // Stop-bit centre sits 9.5 bit periods after the start edge (152
          // clk), plus 2 synchroniser clk and 1 output register clk.
          checkRange("start_to_valid_latency", cycle - startCycle[i], 153, 158);
          latArm[i] = 0;
        end
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_word: dut %0d data %0d err %0d, no word expected",
                   i, dataV[i], errV[i]);
        end else begin
          curExp[i] = expQ.pop_front();
          check("word_dut", i, curExp[i].idx);
          check("word_data", int'(dataV[i]), int'(curExp[i].d));
          check("word_err", int'(errV[i]), int'(curExp[i].e));
        end
      end else if (validV[i] && validPrev[i]) begin
        check("held_data", int'(dataV[i]), int'(curExp[i].d));
        check("held_err", int'(errV[i]), int'(curExp[i].e));
      end
    end
    validPrev = validV;
  end

  task automatic driveBit(input int idx, input logic b);
    rxV[idx] = b;
    repeat (N) @(negedge clk);
  endtask

  // Expected word from the frame contents: err if stop is low or if the
  // count of ones over data+parity contradicts the receiver's parity mode.
  task automatic sendFrame(input int idx, input logic [7:0] d, input logic pbit,
                           input logic stopBit);
    int  ones;
    expT e;
    ones  = $countones(d) + ((idx != 0) ? int'(pbit) : 0);
    e.idx = idx;
    e.d   = d;
    e.e   = !stopBit || (idx == 1 && ones % 2 == 0) || (idx == 2 && ones % 2 == 1);
    if (!pending[idx]) begin
      expQ.push_back(e);
      pending[idx] = 1;
    end
    @(negedge clk);
    startCycle[idx] = cycle;
    driveBit(idx, 1'b0);
    for (int b = 0; b < 8; b++) driveBit(idx, d[b]);
    if (idx != 0) driveBit(idx, pbit);
    driveBit(idx, stopBit);
    rxV[idx] = 1'b1;
  endtask

  task automatic waitValid(input int idx);
    int n = 0;
    while (!validV[idx] && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", int'(validV[idx]), 1);
  endtask

  task automatic ackWord(input int idx, input int hold);
    bit wasPending = pending[idx];
    @(negedge clk);
    if (wasPending) check("valid_before_ack", int'(validV[idx]), 1);
    ackV[idx] = 1'b1;
    @(negedge clk);
    check("valid_after_ack", int'(validV[idx]), 0);
    check("err_after_ack", int'(errV[idx]), 0);
    repeat (hold - 1) @(negedge clk);
    ackV[idx]    = 1'b0;
    pending[idx] = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", int'(validV[i]), 0);
      check("rst_err", int'(errV[i]), 0);
      check("rst_data", int'(dataV[i]), 0);
      check("rst_busy", int'(busyV[i]), 0);
      pending[i] = 0;
    end
    check("queue_empty_at_reset", expQ.size(), 0);
    expQ.delete();
    rst = 1'b0;
    rxV = 3'b111;
    @(negedge clk);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit busySeen;
    rst  = 1'b1;
    rxV  = 3'b000;
    ackV = 3'b000;

    // Reset with the line held low, then release to an idle line.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", int'(validV[i]), 0);
      check("rst_err", int'(errV[i]), 0);
      check("rst_data", int'(dataV[i]), 0);
      check("rst_busy", int'(busyV[i]), 0);
    end
    rst = 1'b0;
    rxV = 3'b111;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 3; i++) check("idle_busy", int'(busyV[i]), 0);
    ackWord(0, 1);  // ack with no word present has no effect

    // Plain 8N1 word with latency measurement; ack 5 clk after valid.
    latArm[0] = 1;
    sendFrame(0, 8'hA5, 1'b0, 1'b1);
    waitValid(0);
    repeat (5) @(negedge clk);
    ackWord(0, 1);

    // Framing error, then a clean frame after ack.
    sendFrame(0, 8'h3C, 1'b0, 1'b0);
    waitValid(0);
    repeat (2) @(negedge clk);
    ackWord(0, 1);
    sendFrame(0, 8'h01, 1'b0, 1'b1);
    waitValid(0);
    ackWord(0, 2);

    // Parity: even receiver then odd receiver, good and bad parity bit.
    sendFrame(2, 8'h07, 1'b1, 1'b1); waitValid(2); ackWord(2, 1);
    sendFrame(2, 8'h07, 1'b0, 1'b1); waitValid(2); ackWord(2, 1);
    sendFrame(1, 8'h07, 1'b1, 1'b1); waitValid(1); ackWord(1, 1);
    sendFrame(1, 8'h07, 1'b0, 1'b1); waitValid(1); ackWord(1, 1);

    // Glitch shorter than half a bit: busy pulses, no word.
    @(negedge clk);
    rxV[0]   = 1'b0;
    busySeen = 0;
    repeat (4) begin
      @(negedge clk);
      busySeen |= busyV[0];
    end
    rxV[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      busySeen |= busyV[0];
    end
    check("glitch_busy_pulse", int'(busySeen), 1);
    check("glitch_busy_end", int'(busyV[0]), 0);
    check("glitch_no_valid", int'(validV[0]), 0);
    sendFrame(0, 8'h55, 1'b0, 1'b1);
    waitValid(0);
    ackWord(0, 1);

    // Break: one word of zeros with err, then silence until the line rises.
    expQ.push_back('{idx: 0, d: 8'h00, e: 1'b1});
    pending[0] = 1;
    @(negedge clk);
    rxV[0] = 1'b0;
    repeat (12 * N) @(negedge clk);
    waitValid(0);
    ackWord(0, 1);
    repeat (4 * N) @(negedge clk);
    check("break_held_busy", int'(busyV[0]), 0);
    check("break_held_valid", int'(validV[0]), 0);
    rxV[0] = 1'b1;
    repeat (4) @(negedge clk);
    sendFrame(0, 8'hC3, 1'b0, 1'b1);
    waitValid(0);
    ackWord(0, 1);

    // Overrun: second frame is dropped while the first is unacknowledged.
    sendFrame(0, 8'h11, 1'b0, 1'b1);
    sendFrame(0, 8'h22, 1'b0, 1'b1);
    repeat (N) @(negedge clk);
    check("overrun_valid", int'(validV[0]), 1);
    check("overrun_data", int'(dataV[0]), 8'h11);

    // Reset mid-frame while a word is pending, then mid-frame while parsing.
    driveBit(0, 1'b0);
    driveBit(0, 1'b1);
    driveBit(0, 1'b1);
    pulseReset();
    driveBit(0, 1'b0);
    driveBit(0, 1'b1);
    check("parse_busy", int'(busyV[0]), 1);
    pulseReset();
    repeat (12 * N) @(negedge clk);
    sendFrame(0, 8'h5A, 1'b0, 1'b1);
    waitValid(0);
    ackWord(0, 1);

    // Randomised frames across the three receivers, with occasional
    // missing acks (overrun), bad stop bits and random parity bits.
    for (int k = 0; k < 36; k++) begin
      int         idx;
      logic [7:0] d;
      idx = int'($urandom_range(0, 2));
      d   = 8'($urandom);
      sendFrame(idx, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0));
      repeat ($urandom_range(1, 10)) @(negedge clk);
      if (pending[idx] && $urandom_range(0, 3) != 0)
        ackWord(idx, int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 3; i++) if (pending[i]) ackWord(i, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
